// File: rtl/ciphertext_compressor.sv
// Compresses a 512-coefficient NewHope polynomial (q = 12289) to 3 bits per coefficient
// and packs the results into 192 bytes in the layout the ciphertext decompressor unpacks.
module ciphertext_compressor (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  output logic [8:0]  poly_addr,
  input  logic [15:0] poly_do,
  output logic        byte_wea,
  output logic [7:0]  byte_addra,
  output logic [7:0]  byte_dia
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          state, state_nxt;
  logic [9:0]      cyc_cnt;
  logic [7:0]      byte_ptr;
  logic [7:0][2:0] r_buf;

  logic [13:0] t_raw, t_red;
  logic [3:0]  thr_cnt;
  logic [2:0]  r_cur;
  logic [9:0]  coef_idx;
  logic [2:0]  lane;
  logic        data_valid;
  logic        wr_now;
  logic [7:0]  wr_data;

  // Reduce once, then count met thresholds; 8 thresholds wrap to 0 via the 3-bit truncation.
  always_comb begin
    t_raw = poly_do[13:0];
    t_red = (t_raw >= 14'd12289) ? (t_raw - 14'd12289) : t_raw;
    thr_cnt = 4'(t_red >= 14'd769)  + 4'(t_red >= 14'd2305) +
              4'(t_red >= 14'd3841) + 4'(t_red >= 14'd5377) +
              4'(t_red >= 14'd6913) + 4'(t_red >= 14'd8449) +
              4'(t_red >= 14'd9985) + 4'(t_red >= 14'd11521);
    r_cur = thr_cnt[2:0];
  end

  // Coefficient i is on poly_do in run cycle i+2; a byte is emitted as soon as its last field arrives.
  always_comb begin
    coef_idx   = cyc_cnt - 10'd2;
    lane       = coef_idx[2:0];
    data_valid = (state == RUN) && (cyc_cnt >= 10'd2) && (cyc_cnt <= 10'd513);
    wr_now     = data_valid && ((lane == 3'd2) || (lane == 3'd5) || (lane == 3'd7));
    wr_data    = 8'd0;
    case (lane)
      3'd2:    wr_data = {r_cur[1:0], r_buf[1], r_buf[0]};
      3'd5:    wr_data = {r_cur[0], r_buf[4], r_buf[3], r_buf[2][2]};
      3'd7:    wr_data = {r_cur, r_buf[6], r_buf[5][2:1]};
      default: wr_data = 8'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cyc_cnt == 10'd514) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign done = (state == FINISH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt    <= 10'd0;
      byte_ptr   <= 8'd0;
      r_buf      <= '0;
      poly_addr  <= 9'd0;
      byte_wea   <= 1'b0;
      byte_addra <= 8'd0;
      byte_dia   <= 8'd0;
    end else begin
      byte_wea <= 1'b0;
      if (state == IDLE && start) begin
        cyc_cnt  <= 10'd0;
        byte_ptr <= 8'd0;
      end else if (state == RUN) begin
        cyc_cnt <= cyc_cnt + 10'd1;
        if (cyc_cnt <= 10'd511) poly_addr <= cyc_cnt[8:0];
        if (data_valid) r_buf[lane] <= r_cur;
        if (wr_now) begin
          byte_wea   <= 1'b1;
          byte_addra <= byte_ptr;
          byte_dia   <= wr_data;
          byte_ptr   <= byte_ptr + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ciphertext_compressor.sv
// Randomised and directed bench for ciphertext_compressor, checked against an
// arithmetic model of the compression formula and the LSB-first 3-bit packing.
module tb_ciphertext_compressor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [8:0]  poly_addr;
  logic [15:0] poly_do = 16'd0;
  logic        byte_wea;
  logic [7:0]  byte_addra;
  logic [7:0]  byte_dia;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [512];
  logic [7:0]  exp_bytes [192];
  logic [7:0]  cap_data [192];
  int          cap_addr [192];
  int          cap_cyc  [192];
  int          n_writes, done_count, done_first, addr_bad, hold_bad, rst_bad, tail_addr;

  ciphertext_compressor dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .poly_addr(poly_addr), .poly_do(poly_do),
    .byte_wea(byte_wea), .byte_addra(byte_addra), .byte_dia(byte_dia)
  );

  always #5 clk = ~clk;

  // One-cycle synchronous-read poly RAM
  always @(posedge clk) poly_do <= mem[poly_addr];

  function automatic int model_r(input logic [15:0] w);
    int t;
    t = int'(w[13:0]);
    if (t >= 12289) t = t - 12289;
    return ((8 * t + 6144) / 12289) % 8;
  endfunction

  function automatic int exp_cyc(input int b);
    int g;
    g = b / 3;
    if (b % 3 == 0) return 8 * g + 5;
    if (b % 3 == 1) return 8 * g + 8;
    return 8 * g + 10;
  endfunction

  task automatic compute_expected();
    logic [1535:0] bits;
    int r;
    bits = '0;
    for (int i = 0; i < 512; i++) begin
      r = model_r(mem[i]);
      bits[3*i +: 3] = r[2:0];
    end
    for (int k = 0; k < 192; k++) exp_bytes[k] = bits[8*k +: 8];
  endtask

  // Sample in mid-cycle k (negedge), then drive stimulus for the next edge.
  task automatic do_run(input int abort_at, input int extra_start_at);
    logic [7:0] last_addr, last_data;
    n_writes = 0; done_count = 0; done_first = -1;
    addr_bad = 0; hold_bad = 0; rst_bad = 0; tail_addr = -1;
    last_addr = 8'd0; last_data = 8'd0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= 530; k++) begin
      @(negedge clk);
      if (byte_wea === 1'b1) begin
        if (n_writes < 192) begin
          cap_data[n_writes] = byte_dia;
          cap_addr[n_writes] = int'(byte_addra);
          cap_cyc[n_writes]  = k;
        end
        n_writes++;
        last_addr = byte_addra;
        last_data = byte_dia;
      end else if (n_writes > 0 && abort_at == 0) begin
        if (byte_addra !== last_addr || byte_dia !== last_data) hold_bad++;
      end
      if (done === 1'b1) begin
        done_count++;
        if (done_first < 0) done_first = k;
      end
      if (abort_at == 0 && k <= 512 && poly_addr !== 9'(k - 1)) addr_bad++;
      if (k == 520) tail_addr = int'(poly_addr);
      if (abort_at != 0 && k == abort_at + 1 &&
          (done !== 1'b0 || byte_wea !== 1'b0 || poly_addr !== 9'd0 ||
           byte_addra !== 8'd0 || byte_dia !== 8'd0)) rst_bad++;
      start = (k == extra_start_at);
      if (abort_at != 0 && k == abort_at) rst = 1'b1;
      if (abort_at != 0 && k == abort_at + 3) rst = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic check_full_run(input string name);
    int nw;
    n_checks++;
    if (n_writes != 192) begin
      n_fail++;
      $display("[TB] FAIL %s write_count: got %0d expected 192", name, n_writes);
    end
    nw = (n_writes < 192) ? n_writes : 192;
    for (int b = 0; b < nw; b++) begin
      n_checks++;
      if (cap_addr[b] != b || cap_data[b] !== exp_bytes[b] || cap_cyc[b] != exp_cyc(b)) begin
        n_fail++;
        $display("[TB] FAIL %s write[%0d]: got addr=%0d data=%02h cycle=%0d expected addr=%0d data=%02h cycle=%0d",
                 name, b, cap_addr[b], cap_data[b], cap_cyc[b], b, exp_bytes[b], exp_cyc(b));
      end
    end
    n_checks++;
    if (done_count != 1 || done_first != 515) begin
      n_fail++;
      $display("[TB] FAIL %s done: got %0d pulses first at cycle %0d expected 1 pulse at 515", name, done_count, done_first);
    end
    n_checks++;
    if (addr_bad != 0) begin
      n_fail++;
      $display("[TB] FAIL %s poly_addr_sweep: got %0d bad cycles expected 0", name, addr_bad);
    end
    n_checks++;
    if (tail_addr != 511) begin
      n_fail++;
      $display("[TB] FAIL %s poly_addr_hold: got %0d expected 511", name, tail_addr);
    end
    n_checks++;
    if (hold_bad != 0) begin
      n_fail++;
      $display("[TB] FAIL %s byte_port_hold: got %0d changes while idle expected 0", name, hold_bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || byte_wea !== 1'b0 || poly_addr !== 9'd0 || byte_addra !== 8'd0 || byte_dia !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got done=%b wea=%b paddr=%0d baddr=%0d bdata=%02h expected all 0",
               done, byte_wea, poly_addr, byte_addra, byte_dia);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    for (int i = 0; i < 512; i++) mem[i] = 16'd0;
    compute_expected();
    do_run(0, 0);
    check_full_run("zero");
  endtask

  task automatic test_const_one();
    for (int i = 0; i < 512; i++) mem[i] = 16'd1536;
    compute_expected();
    do_run(0, 0);
    check_full_run("const_r1");
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 512; i++) mem[i] = 16'(1536 * (i % 8));
    compute_expected();
    do_run(0, 0);
    check_full_run("ramp_r0to7");
  endtask

  task automatic test_boundary();
    logic [15:0] bvals [8];
    bvals = '{16'd768, 16'd769, 16'd11520, 16'd11521, 16'd12288, 16'd12289, 16'd12290, 16'd16383};
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) mem[i] = bvals[i];
    compute_expected();
    do_run(0, 0);
    check_full_run("boundary");
  endtask

  task automatic test_random();
    logic [1535:0] bits;
    int r_got, r_exp;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom_range(0, 12288));
    compute_expected();
    do_run(0, 0);
    check_full_run("random");
    bits = '0;
    for (int k = 0; k < 192; k++) bits[8*k +: 8] = cap_data[k];
    for (int i = 0; i < 512; i++) begin
      r_got = int'(bits[3*i +: 3]);
      r_exp = model_r(mem[i]);
      n_checks++;
      if ((12289 * r_got + 4) / 8 != (12289 * r_exp + 4) / 8) begin
        n_fail++;
        $display("[TB] FAIL decompress[%0d]: got %0d expected %0d", i, (12289 * r_got + 4) / 8, (12289 * r_exp + 4) / 8);
      end
    end
  endtask

  task automatic test_reset_abort();
    int exp_n;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom_range(0, 12288));
    compute_expected();
    do_run(200, 100);
    exp_n = 0;
    for (int b = 0; b < 192; b++) if (exp_cyc(b) <= 200) exp_n++;
    n_checks++;
    if (n_writes != exp_n) begin
      n_fail++;
      $display("[TB] FAIL abort_write_count: got %0d expected %0d", n_writes, exp_n);
    end
    for (int b = 0; b < exp_n && b < n_writes; b++) begin
      n_checks++;
      if (cap_addr[b] != b || cap_data[b] !== exp_bytes[b] || cap_cyc[b] != exp_cyc(b)) begin
        n_fail++;
        $display("[TB] FAIL abort_write[%0d]: got addr=%0d data=%02h cycle=%0d expected addr=%0d data=%02h cycle=%0d",
                 b, cap_addr[b], cap_data[b], cap_cyc[b], b, exp_bytes[b], exp_cyc(b));
      end
    end
    n_checks++;
    if (done_count != 0) begin
      n_fail++;
      $display("[TB] FAIL abort_done: got %0d pulses expected 0", done_count);
    end
    n_checks++;
    if (rst_bad != 0) begin
      n_fail++;
      $display("[TB] FAIL abort_reset_outputs: got %0d nonzero samples expected 0", rst_bad);
    end
    do_run(0, 0);
    check_full_run("after_abort");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    compute_expected();
    do_run(0, 300);
    check_full_run("back_to_back_a");
    do_run(0, 0);
    check_full_run("back_to_back_b");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_const_one();
    test_ramp();
    test_boundary();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
